divisor_arbiter: RTL and testbench

Round-robin scheduler that shares one Divisor_Algoritmico instance between N_REQ requesters. It arbitrates among pending requests and captures the winner's operands. It sequences the divider's Start/Done handshake, then returns the quotient and remainder to the winning requester with a one-cycle valid pulse. Division by zero is trapped and never reaches the divider.

---
 rtl/divisor_pkg.sv | 19 +
 rtl/Divisor_Algoritmico.sv | 99 +++++++++
 rtl/rr_arbiter_n.sv | 33 +++
 rtl/divisor_arbiter.sv | 155 +++++++++++++++
 tb/tb_divisor_arbiter.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/divisor_pkg.sv
// Shared types for the divider arbiter: FSM state encoding and grant-index width helper.
package divisor_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      RELEASE,
      ZERO
   } state_t;

   // Width of a requester index; at least one bit even for two requesters.
   function automatic int unsigned idx_w(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   localparam int unsigned N_REQ_DEF = 4;
   localparam int unsigned GNT_W     = idx_w(N_REQ_DEF);

endpackage

// File: rtl/Divisor_Algoritmico.sv
// Multi-cycle signed restoring divider shared by the arbiter.
// Ports: CLK/RSTa clock and async active-low reset; Start level request
// (operands sampled when idle); Num/Den signed operands; Done held high from
// completion until Start drops; Coc truncating quotient; Res remainder with
// the numerator's sign. Den = 0 is never presented by the arbiter.
module Divisor_Algoritmico #(
   parameter int unsigned tamanyo = 32
) (
   input  logic               CLK,
   input  logic               RSTa,
   input  logic               Start,
   input  logic [tamanyo-1:0] Num,
   input  logic [tamanyo-1:0] Den,
   output logic               Done,
   output logic [tamanyo-1:0] Coc,
   output logic [tamanyo-1:0] Res
);

   localparam int unsigned W  = tamanyo;
   localparam int unsigned CW = $clog2(W);

   typedef enum logic [1:0] {
      D_IDLE,
      D_BUSY,
      D_DONE
   } dstate_t;

   dstate_t        state_q, state_n;
   logic [W-1:0]   quo_q, mag_b_q, rem_q;
   logic [CW-1:0]  cnt_q;
   logic           neg_quo_q, neg_rem_q;
   logic [W:0]     rem_sh, rem_nx;
   logic           fits;
   logic [W-1:0]   quo_nx;

   // One restoring step on magnitudes; the remainder never exceeds the divisor,
   // so one extra bit is enough for the shifted partial remainder.
   always_comb begin
      rem_sh = {rem_q, quo_q[W-1]};
      fits   = rem_sh >= {1'b0, mag_b_q};
      rem_nx = fits ? (rem_sh - {1'b0, mag_b_q}) : rem_sh;
      quo_nx = {quo_q[W-2:0], fits};
   end

   // State register.
   always_ff @(posedge CLK or negedge RSTa) begin
      if (!RSTa) state_q <= D_IDLE;
      else       state_q <= state_n;
   end

   // Next-state logic.
   always_comb begin
      state_n = state_q;
      case (state_q)
         D_IDLE:  if (Start) state_n = D_BUSY;
         D_BUSY:  if (cnt_q == '0) state_n = D_DONE;
         D_DONE:  if (!Start) state_n = D_IDLE;
         default: state_n = D_IDLE;
      endcase
   end

   // Datapath and registered results.
   always_ff @(posedge CLK or negedge RSTa) begin
      if (!RSTa) begin
         quo_q     <= '0;
         mag_b_q   <= '0;
         rem_q     <= '0;
         cnt_q     <= '0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         Done      <= 1'b0;
         Coc       <= '0;
         Res       <= '0;
      end else begin
         Done <= (state_n == D_DONE);
         case (state_q)
            D_IDLE: if (Start) begin
               quo_q     <= Num[W-1] ? W'(-Num) : Num;
               mag_b_q   <= Den[W-1] ? W'(-Den) : Den;
               rem_q     <= '0;
               cnt_q     <= CW'(W - 1);
               neg_quo_q <= Num[W-1] ^ Den[W-1];
               neg_rem_q <= Num[W-1];
            end
            D_BUSY: begin
               quo_q <= quo_nx;
               rem_q <= W'(rem_nx);
               cnt_q <= cnt_q - CW'(1);
               if (cnt_q == '0) begin
                  Coc <= neg_quo_q ? W'(-quo_nx) : quo_nx;
                  Res <= neg_rem_q ? W'(-rem_nx) : W'(rem_nx);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/rr_arbiter_n.sv
// Combinational round-robin grant: first set request at or above ptr, wrapping.
// Ports: req request vector; ptr search start; grant one-hot winner;
// idx winner index; any high when at least one request is pending.
module rr_arbiter_n #(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned IW    = 2
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IW-1:0]    ptr,
   output logic [N_REQ-1:0] grant,
   output logic [IW-1:0]    idx,
   output logic             any
);

   logic [IW-1:0] slot;

   // Scan N_REQ slots starting at ptr; the first pending one wins.
   always_comb begin
      idx  = '0;
      any  = 1'b0;
      slot = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         slot = IW'((32'(ptr) + i) % N_REQ);
         if (!any && req[slot]) begin
            any = 1'b1;
            idx = slot;
         end
      end
   end

   assign grant = any ? (N_REQ'(1) << idx) : '0;

endmodule

// File: rtl/divisor_arbiter.sv
// Round-robin scheduler sharing one Divisor_Algoritmico among N_REQ requesters.
// Ports: CLK/RSTa clock and async active-low reset; req/num_i/den_i requester
// side (packed slots of tamanyo bits); ack operand-capture pulse; rsp_valid
// result pulse with coc_o/res_o/div0_o; busy when not idle; div_* divider
// handshake (Start held until Done, then Done must fall before the next job).
module divisor_arbiter
   import divisor_pkg::*;
#(
   parameter int unsigned tamanyo = 32,
   parameter int unsigned N_REQ   = 4
) (
   input  logic                     CLK,
   input  logic                     RSTa,
   input  logic [N_REQ-1:0]         req,
   input  logic [N_REQ*tamanyo-1:0] num_i,
   input  logic [N_REQ*tamanyo-1:0] den_i,
   output logic [N_REQ-1:0]         ack,
   output logic [N_REQ-1:0]         rsp_valid,
   output logic [tamanyo-1:0]       coc_o,
   output logic [tamanyo-1:0]       res_o,
   output logic                     div0_o,
   output logic                     busy,
   output logic                     div_start,
   input  logic                     div_done,
   output logic [tamanyo-1:0]       div_num,
   output logic [tamanyo-1:0]       div_den,
   input  logic [tamanyo-1:0]       div_coc,
   input  logic [tamanyo-1:0]       div_res
);

   localparam int unsigned W  = tamanyo;
   localparam int unsigned IW = idx_w(N_REQ);

   state_t           state_q, state_n;
   logic [IW-1:0]    ptr_q, ptr_n;
   logic [IW-1:0]    g_q, g_n;
   logic [N_REQ-1:0] ack_q, ack_n, rsp_q, rsp_n;
   logic             start_q, start_n;
   logic [W-1:0]     num_q, num_n, den_q, den_n;
   logic [W-1:0]     coc_q, coc_n, res_q, res_n;
   logic             d0_q, d0_n, busy_q;

   logic [N_REQ-1:0] gnt;
   logic [IW-1:0]    gnt_idx;
   logic             gnt_any;
   logic [W-1:0]     sel_num, sel_den;

   rr_arbiter_n #(
      .N_REQ (N_REQ),
      .IW    (IW)
   ) u_rr (
      .req   (req),
      .ptr   (ptr_q),
      .grant (gnt),
      .idx   (gnt_idx),
      .any   (gnt_any)
   );

   assign sel_num = num_i[int'(gnt_idx)*W +: W];
   assign sel_den = den_i[int'(gnt_idx)*W +: W];

   // Registered state and outputs.
   always_ff @(posedge CLK or negedge RSTa) begin
      if (!RSTa) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         g_q     <= '0;
         ack_q   <= '0;
         rsp_q   <= '0;
         start_q <= 1'b0;
         num_q   <= '0;
         den_q   <= '0;
         coc_q   <= '0;
         res_q   <= '0;
         d0_q    <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_n;
         ptr_q   <= ptr_n;
         g_q     <= g_n;
         ack_q   <= ack_n;
         rsp_q   <= rsp_n;
         start_q <= start_n;
         num_q   <= num_n;
         den_q   <= den_n;
         coc_q   <= coc_n;
         res_q   <= res_n;
         d0_q    <= d0_n;
         busy_q  <= (state_n != IDLE);
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_n = state_q;
      ptr_n   = ptr_q;
      g_n     = g_q;
      ack_n   = '0;
      rsp_n   = '0;
      start_n = 1'b0;
      num_n   = num_q;
      den_n   = den_q;
      coc_n   = coc_q;
      res_n   = res_q;
      d0_n    = d0_q;
      case (state_q)
         IDLE: if (gnt_any) begin
            g_n   = gnt_idx;
            ack_n = gnt;
            ptr_n = (gnt_idx == IW'(N_REQ - 1)) ? '0 : gnt_idx + IW'(1);
            num_n = sel_num;
            den_n = sel_den;
            // A zero divisor is answered locally and never reaches the divider.
            if (sel_den == '0) begin
               state_n = ZERO;
            end else begin
               start_n = 1'b1;
               state_n = ISSUE;
            end
         end
         ISSUE: begin
            if (div_done) begin
               coc_n   = div_coc;
               res_n   = div_res;
               d0_n    = 1'b0;
               rsp_n   = N_REQ'(1) << g_q;
               state_n = RELEASE;
            end else begin
               start_n = 1'b1;
            end
         end
         // Wait for Done to fall so a level-held Done is not seen as the next completion.
         RELEASE: if (!div_done) state_n = IDLE;
         ZERO: begin
            coc_n   = '0;
            res_n   = num_q;
            d0_n    = 1'b1;
            rsp_n   = N_REQ'(1) << g_q;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   assign ack       = ack_q;
   assign rsp_valid = rsp_q;
   assign coc_o     = coc_q;
   assign res_o     = res_q;
   assign div0_o    = d0_q;
   assign busy      = busy_q;
   assign div_start = start_q;
   assign div_num   = num_q;
   assign div_den   = den_q;

endmodule

// File: tb/tb_divisor_arbiter.sv
// Self-checking bench for divisor_arbiter driving a real Divisor_Algoritmico.
module tb_divisor_arbiter;

   localparam int unsigned W = 32;
   localparam int unsigned N = 4;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [N-1:0]   req = '0;
   logic [N*W-1:0] num_i = '0, den_i = '0;
   logic [N-1:0]   ack, rsp_valid;
   logic [W-1:0]   coc_o, res_o, div_num, div_den, div_coc, div_res;
   logic           div0_o, busy, div_start, div_done;

   divisor_arbiter #(.tamanyo(W), .N_REQ(N)) dut (
      .CLK(clk), .RSTa(rst_n), .req(req), .num_i(num_i), .den_i(den_i),
      .ack(ack), .rsp_valid(rsp_valid), .coc_o(coc_o), .res_o(res_o),
      .div0_o(div0_o), .busy(busy), .div_start(div_start), .div_done(div_done),
      .div_num(div_num), .div_den(div_den), .div_coc(div_coc), .div_res(div_res)
   );

   Divisor_Algoritmico #(.tamanyo(W)) u_div (
      .CLK(clk), .RSTa(rst_n), .Start(div_start), .Num(div_num), .Den(div_den),
      .Done(div_done), .Coc(div_coc), .Res(div_res)
   );

   always #5 clk = ~clk;

   int           n_vec = 0;
   int           n_err = 0;
   int           model_ptr;
   int           ack_q[$];
   int           rsp_q[$];
   logic [W-1:0] obs_coc[N];
   logic [W-1:0] obs_res[N];
   logic         obs_d0[N];
   bit           onehot_bad, timed_out;

   // Reference: truncating division, remainder follows numerator; den=0 -> (0, num).
   function automatic void ref_div(input logic [W-1:0] n, input logic [W-1:0] d,
                                   output logic [W-1:0] q, output logic [W-1:0] r);
      int sn, sd;
      sn = int'(n);
      sd = int'(d);
      if (sd == 0) begin
         q = '0;
         r = n;
      end else begin
         q = W'(sn / sd);
         r = W'(sn % sd);
      end
   endfunction

   task automatic set_op(input int i, input int n, input int d);
      num_i[i*W +: W] = W'(n);
      den_i[i*W +: W] = W'(d);
   endtask

   task automatic do_reset();
      req   = '0;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      model_ptr = 0;
   endtask

   // Raise the masked requests together and collect acks/responses until every job answers.
   task automatic serve(input logic [N-1:0] mask);
      int want, got, cyc;
      ack_q.delete();
      rsp_q.delete();
      onehot_bad = 1'b0;
      timed_out  = 1'b0;
      want = $countones(mask);
      got  = 0;
      cyc  = 0;
      @(negedge clk);
      req = req | mask;
      while (got < want && cyc < 400 * N) begin
         @(posedge clk);
         #1;
         cyc++;
         if (ack != '0) begin
            if ($countones(ack) != 1) onehot_bad = 1'b1;
            for (int i = 0; i < N; i++) if (ack[i]) begin
               ack_q.push_back(i);
               req[i] = 1'b0;
            end
         end
         if (rsp_valid != '0) begin
            if ($countones(rsp_valid) != 1) onehot_bad = 1'b1;
            for (int i = 0; i < N; i++) if (rsp_valid[i]) begin
               rsp_q.push_back(i);
               obs_coc[i] = coc_o;
               obs_res[i] = res_o;
               obs_d0[i]  = div0_o;
               got++;
            end
         end
      end
      if (got < want) timed_out = 1'b1;
   endtask

   task automatic test_reset();
      req   = '0;
      rst_n = 1'b0;
      #1;
      n_vec++;
      if ({ack, rsp_valid, coc_o, res_o, div0_o, busy, div_start, div_num, div_den} !== '0) begin
         n_err++;
         $display("FAIL reset_outputs: got ack=%b rsp=%b coc=%0d res=%0d d0=%b busy=%b start=%b num=%0d den=%0d, expected all zero",
                  ack, rsp_valid, coc_o, res_o, div0_o, busy, div_start, div_num, div_den);
      end
      do_reset();
      n_vec++;
      if (busy !== 1'b0 || div_done !== 1'b0) begin
         n_err++;
         $display("FAIL reset_idle: got busy=%b done=%b expected 0 0", busy, div_done);
      end
   endtask

   task automatic test_single();
      int cyc;
      do_reset();
      set_op(0, 15, 3);
      req = 4'b0001;
      @(posedge clk);
      #1;
      n_vec++;
      if (ack !== 4'b0001) begin
         n_err++;
         $display("FAIL single_ack: got %b expected 0001", ack);
      end
      req = '0;
      cyc = 0;
      while (rsp_valid == '0 && cyc < 200) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      n_vec++;
      if (rsp_valid !== 4'b0001 || coc_o !== 32'd5 || res_o !== 32'd0 || div0_o !== 1'b0) begin
         n_err++;
         $display("FAIL single_rsp: got rsp=%b coc=%0d res=%0d d0=%b expected 0001 5 0 0",
                  rsp_valid, $signed(coc_o), $signed(res_o), div0_o);
      end
      @(posedge clk);
      #1;
      n_vec++;
      if (rsp_valid !== 4'b0000 || coc_o !== 32'd5) begin
         n_err++;
         $display("FAIL single_pulse_hold: got rsp=%b coc=%0d expected 0000 5", rsp_valid, $signed(coc_o));
      end
   endtask

   task automatic test_signed();
      int nums[3] = '{-17, -23, 17};
      int dens[3] = '{3, -5, -3};
      int qs[3]   = '{-5, 4, -5};
      int rs[3]   = '{-2, -3, 2};
      do_reset();
      for (int k = 0; k < 3; k++) begin
         set_op(1, nums[k], dens[k]);
         serve(4'b0010);
         n_vec++;
         if (timed_out || rsp_q.size() != 1 || obs_coc[1] !== W'(qs[k]) ||
             obs_res[1] !== W'(rs[k]) || obs_d0[1] !== 1'b0) begin
            n_err++;
            $display("FAIL signed_%0d: got coc=%0d res=%0d d0=%b to=%b expected %0d %0d 0",
                     k, $signed(obs_coc[1]), $signed(obs_res[1]), obs_d0[1], timed_out, qs[k], rs[k]);
         end
      end
   endtask

   task automatic test_all_four();
      int qs[N] = '{5, 5, 5, -6};
      int rs[N] = '{0, 2, 0, 0};
      do_reset();
      set_op(0, 15, 3);
      set_op(1, 17, 3);
      set_op(2, -15, -3);
      set_op(3, -18, 3);
      serve(4'b1111);
      n_vec++;
      if (timed_out || onehot_bad || ack_q.size() != 4 || rsp_q.size() != 4) begin
         n_err++;
         $display("FAIL all4_handshake: got acks=%0d rsps=%0d onehot_bad=%b timeout=%b expected 4 4 0 0",
                  ack_q.size(), rsp_q.size(), onehot_bad, timed_out);
      end else begin
         for (int i = 0; i < N; i++) begin
            n_vec++;
            if (ack_q[i] != i || rsp_q[i] != i) begin
               n_err++;
               $display("FAIL all4_order_%0d: got ack=%0d rsp=%0d expected %0d", i, ack_q[i], rsp_q[i], i);
            end
            n_vec++;
            if (obs_coc[i] !== W'(qs[i]) || obs_res[i] !== W'(rs[i]) || obs_d0[i] !== 1'b0) begin
               n_err++;
               $display("FAIL all4_result_%0d: got coc=%0d res=%0d d0=%b expected %0d %0d 0",
                        i, $signed(obs_coc[i]), $signed(obs_res[i]), obs_d0[i], qs[i], rs[i]);
            end
         end
      end
   endtask

   task automatic test_fairness();
      int cyc, jobs0;
      bit got2, rsp2;
      do_reset();
      set_op(0, 9, 2);
      set_op(2, 100, 7);
      req = 4'b0001;
      cyc = 0;
      while (ack[0] !== 1'b1 && cyc < 20) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      req[2] = 1'b1;
      jobs0  = 0;
      got2   = 1'b0;
      rsp2   = 1'b0;
      cyc    = 0;
      while (!rsp2 && cyc < 600) begin
         @(posedge clk);
         #1;
         cyc++;
         if (ack[0] && !got2) jobs0++;
         if (ack[2]) begin
            got2 = 1'b1;
            req  = '0;
         end
         if (rsp_valid[2]) begin
            rsp2 = 1'b1;
            n_vec++;
            if (coc_o !== 32'd14 || res_o !== 32'd2) begin
               n_err++;
               $display("FAIL fair_result: got coc=%0d res=%0d expected 14 2", $signed(coc_o), $signed(res_o));
            end
         end
      end
      n_vec++;
      if (!rsp2 || jobs0 > 1) begin
         n_err++;
         $display("FAIL fair_wait: got served=%b extra_jobs0=%0d expected 1 and <=1", rsp2, jobs0);
      end
      cyc = 0;
      while (busy && cyc < 100) begin
         @(posedge clk);
         #1;
         cyc++;
      end
   endtask

   task automatic test_div_zero();
      int cyc, lat;
      bit start_seen;
      do_reset();
      set_op(3, -7, 0);
      req = 4'b1000;
      start_seen = 1'b0;
      cyc = 0;
      while (ack[3] !== 1'b1 && cyc < 20) begin
         @(posedge clk);
         #1;
         cyc++;
         if (div_start) start_seen = 1'b1;
      end
      req = '0;
      lat = 0;
      while (rsp_valid == '0 && lat < 10) begin
         @(posedge clk);
         #1;
         lat++;
         if (div_start) start_seen = 1'b1;
      end
      n_vec++;
      if (lat < 1 || lat > 2) begin
         n_err++;
         $display("FAIL div0_latency: got %0d cycles after ack, expected 1..2", lat);
      end
      n_vec++;
      if (rsp_valid !== 4'b1000 || coc_o !== 32'd0 || res_o !== W'(-7) || div0_o !== 1'b1) begin
         n_err++;
         $display("FAIL div0_rsp: got rsp=%b coc=%0d res=%0d d0=%b expected 1000 0 -7 1",
                  rsp_valid, $signed(coc_o), $signed(res_o), div0_o);
      end
      repeat (4) begin
         @(posedge clk);
         #1;
         if (div_start) start_seen = 1'b1;
      end
      n_vec++;
      if (start_seen || busy) begin
         n_err++;
         $display("FAIL div0_no_start: got start_seen=%b busy=%b expected 0 0", start_seen, busy);
      end
   endtask

   task automatic test_reset_mid_job();
      int cyc;
      bit stale;
      do_reset();
      set_op(0, 15, 3);
      req = 4'b0001;
      cyc = 0;
      while (div_start !== 1'b1 && cyc < 20) begin
         @(posedge clk);
         #1;
         cyc++;
         if (ack[0]) req = '0;
      end
      req = '0;
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      n_vec++;
      if ({ack, rsp_valid, coc_o, res_o, div0_o, busy, div_start, div_num, div_den} !== '0) begin
         n_err++;
         $display("FAIL midjob_reset: got busy=%b start=%b num=%0d den=%0d expected all outputs 0",
                  busy, div_start, div_num, div_den);
      end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      stale = 1'b0;
      repeat (60) begin
         @(posedge clk);
         #1;
         if (rsp_valid != '0 || ack != '0) stale = 1'b1;
      end
      n_vec++;
      if (stale) begin
         n_err++;
         $display("FAIL midjob_stale: got stale pulse=1 expected 0");
      end
      serve(4'b0001);
      n_vec++;
      if (timed_out || obs_coc[0] !== 32'd5 || obs_res[0] !== 32'd0 || obs_d0[0] !== 1'b0) begin
         n_err++;
         $display("FAIL midjob_rerun: got coc=%0d res=%0d d0=%b to=%b expected 5 0 0 0",
                  $signed(obs_coc[0]), $signed(obs_res[0]), obs_d0[0], timed_out);
      end
   endtask

   task automatic test_random();
      logic [N-1:0] mask;
      logic [W-1:0] eq, er;
      int exp_q[$];
      int n, d, idx;
      bit order_ok;
      do_reset();
      for (int r = 0; r < 12; r++) begin
         mask = N'($urandom_range(1, (1 << N) - 1));
         for (int i = 0; i < N; i++) begin
            n = int'($urandom);
            if ($urandom_range(0, 1) == 1) n = int'($urandom_range(0, 2000)) - 1000;
            d = int'($urandom_range(1, 50));
            if ($urandom_range(0, 1) == 1) d = -d;
            if ($urandom_range(0, 3) == 0) d = int'($urandom);
            if ($urandom_range(0, 4) == 0) d = 0;
            if (d == -1 && n == int'(32'h8000_0000)) d = 3;
            set_op(i, n, d);
         end
         exp_q.delete();
         for (int k = 0; k < N; k++) begin
            idx = (model_ptr + k) % N;
            if (mask[idx]) exp_q.push_back(idx);
         end
         model_ptr = (exp_q[exp_q.size()-1] + 1) % N;
         serve(mask);
         order_ok = (ack_q.size() == exp_q.size()) && (rsp_q.size() == exp_q.size());
         if (order_ok)
            for (int k = 0; k < exp_q.size(); k++)
               if (ack_q[k] != exp_q[k] || rsp_q[k] != exp_q[k]) order_ok = 1'b0;
         n_vec++;
         if (timed_out || onehot_bad || !order_ok) begin
            n_err++;
            $display("FAIL rand%0d_order: mask=%b got acks=%0d rsps=%0d onehot_bad=%b timeout=%b, expected RR order from %0d",
                     r, mask, ack_q.size(), rsp_q.size(), onehot_bad, timed_out, exp_q[0]);
         end
         for (int i = 0; i < N; i++) if (mask[i]) begin
            ref_div(num_i[i*W +: W], den_i[i*W +: W], eq, er);
            n_vec++;
            if (obs_coc[i] !== eq || obs_res[i] !== er || obs_d0[i] !== (den_i[i*W +: W] == '0)) begin
               n_err++;
               $display("FAIL rand%0d_req%0d: got coc=%0d res=%0d d0=%b expected %0d %0d %b", r, i,
                        $signed(obs_coc[i]), $signed(obs_res[i]), obs_d0[i],
                        $signed(eq), $signed(er), den_i[i*W +: W] == '0);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_signed();
      test_all_four();
      test_fairness();
      test_div_zero();
      test_reset_mid_job();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
